mips_state_dumper: RTL

MIPS_STATE_DUMPER -- requirements
Module: mips_state_dumper

---
 rtl/mips_pkg.sv | 20 ++
 rtl/dump_index_counter.sv | 29 ++
 rtl/mips_state_dumper.sv | 108 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// mips_pkg: FSM state encoding and dump-source tags shared by the state dumper.
// Rev 1.0
package mips_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_DUMP_REG = 3'd2;
  localparam logic [2:0] ST_DUMP_MEM = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic SRC_REG = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dump_index_counter.sv
`default_nettype none
// dump_index_counter: handshake word index that wraps to zero after the terminal value.
// Rev 1.0
module dump_index_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal,
  output logic [W-1:0] count,
  output logic         at_terminal
);

  assign at_terminal = (count == terminal);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_terminal ? '0 : count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_state_dumper.sv
`default_nettype none
// mips_state_dumper: lets the core run until halt or cycle limit, then streams the
// register file and data memory out over a valid/ready port. Rev 1.0
module mips_state_dumper
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int DMEM_DEPTH  = 256,
  parameter int CYCLE_LIMIT = 50,
  localparam int REG_AW = $clog2(NUM_REGS),
  localparam int MEM_AW = $clog2(DMEM_DEPTH),
  localparam int IDX_W  = max_int(REG_AW, MEM_AW)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  output logic              cpu_stall,
  output logic [REG_AW-1:0] reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [MEM_AW-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic [IDX_W-1:0]  out_index,
  output logic              done,
  output logic [31:0]       run_cycles
);

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] terminal;
  logic             at_terminal;
  logic             dumping;
  logic             xfer;
  logic             limit_hit;
  logic             restart;

  assign dumping   = (state == ST_DUMP_REG) || (state == ST_DUMP_MEM);
  assign xfer      = dumping && out_ready;
  assign terminal  = (state == ST_DUMP_MEM) ? IDX_W'(DMEM_DEPTH - 1) : IDX_W'(NUM_REGS - 1);
  assign restart   = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Widened compare so a saturated counter cannot wrap into a false match.
  assign limit_hit = (CYCLE_LIMIT != 0) &&
                     (({1'b0, run_cycles} + 33'd1) == 33'(CYCLE_LIMIT));

  assign cpu_stall = (state != ST_RUN);
  assign done      = (state == ST_DONE);
  assign out_valid = dumping;
  assign out_src   = (state == ST_DUMP_MEM) ? SRC_MEM : SRC_REG;
  assign out_index = idx;
  assign out_data  = (state == ST_DUMP_MEM) ? mem_rdata : reg_rdata;
  assign reg_raddr = (state == ST_DUMP_REG) ? idx[REG_AW-1:0] : '0;
  assign mem_raddr = (state == ST_DUMP_MEM) ? idx[MEM_AW-1:0] : '0;

  dump_index_counter #(
    .W (IDX_W)
  ) u_index (
    .clock       (clock),
    .reset       (reset),
    .clear       (!dumping),
    .enable      (xfer),
    .terminal    (terminal),
    .count       (idx),
    .at_terminal (at_terminal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      run_cycles <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (restart) begin
            state      <= ST_RUN;
            run_cycles <= '0;
          end
        end
        ST_RUN: begin
          if (run_cycles != '1) begin
            run_cycles <= run_cycles + 32'd1;
          end
          if (halt_req || limit_hit) begin
            state <= ST_DUMP_REG;
          end
        end
        ST_DUMP_REG: begin
          if (xfer && at_terminal) begin
            state <= ST_DUMP_MEM;
          end
        end
        ST_DUMP_MEM: begin
          if (xfer && at_terminal) begin
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
